axi_lite_cfg_master: RTL and testbench

//  AXI-Lite initiator that programs and reads back the video-enhancement chip's parameter space
//  (GLUT entries, contrast, brightness) through the chip's AXI-Lite slave port.

---
 rtl/axi_lite_cfg_master_if.sv | 30 +++
 rtl/axi_lite_cfg_master.sv | 128 ++++++++++++
 tb/tb_axi_lite_cfg_master.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_cfg_master_if.sv
// axi_lite_if: AXI-Lite write/read channels between a configuration master and a slave
interface axi_lite_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_cfg_master.sv
// axi_lite_cfg_master: runs one AXI-Lite write or read per command and returns status/data on a response port
module axi_lite_cfg_master #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              busy,
  output logic              timeout,
  axi_lite_if.master        axi
);
  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;
  state_t      state;
  logic [15:0] cnt;
  logic        aw_ok, w_ok, stall, hit;
  // A write channel counts as done once its valid has dropped or is handshaking now
  always_comb begin
    aw_ok = !axi.awvalid || axi.awready;
    w_ok  = !axi.wvalid || axi.wready;
    stall = (state == WR_AW_W && !(aw_ok && w_ok)) || (state == WR_B && !axi.bvalid) ||
            (state == RD_AR && !axi.arready) || (state == RD_R && !axi.rvalid);
    hit   = (TIMEOUT_CYC != 0) && ({1'b0, cnt} + 17'd1 >= 17'(TIMEOUT_CYC));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
      busy        <= 1'b0;
      timeout     <= 1'b0;
      axi.awaddr  <= '0;
      axi.awvalid <= 1'b0;
      axi.wdata   <= '0;
      axi.wvalid  <= 1'b0;
      axi.bready  <= 1'b0;
      axi.araddr  <= '0;
      axi.arvalid <= 1'b0;
      axi.rready  <= 1'b0;
    end else begin
      if (stall) begin
        if (cnt != 16'hffff) cnt <= cnt + 16'd1;
        if (hit) timeout <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            timeout   <= 1'b0;
            cnt       <= '0;
            if (cmd_write) begin
              axi.awaddr  <= cmd_addr;
              axi.wdata   <= cmd_wdata;
              axi.awvalid <= 1'b1;
              axi.wvalid  <= 1'b1;
              state       <= WR_AW_W;
            end else begin
              axi.araddr  <= cmd_addr;
              axi.arvalid <= 1'b1;
              state       <= RD_AR;
            end
          end else cmd_ready <= 1'b1;
        end
        WR_AW_W: begin
          axi.awvalid <= axi.awvalid && !axi.awready;
          axi.wvalid  <= axi.wvalid && !axi.wready;
          if (aw_ok && w_ok) begin
            axi.bready <= 1'b1;
            cnt        <= '0;
            state      <= WR_B;
          end
        end
        WR_B: begin
          if (axi.bvalid) begin
            axi.bready <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_write  <= 1'b1;
            rsp_rdata  <= '0;
            rsp_resp   <= axi.bresp;
            state      <= RSP;
          end
        end
        RD_AR: begin
          if (axi.arready) begin
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b1;
            cnt         <= '0;
            state       <= RD_R;
          end
        end
        RD_R: begin
          if (axi.rvalid) begin
            axi.rready <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_write  <= 1'b0;
            rsp_rdata  <= axi.rdata;
            rsp_resp   <= axi.rresp;
            state      <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_lite_cfg_master.sv
// tb_axi_lite_cfg_master: directed transactions against a delay-programmable AXI-Lite slave with a transaction-level model
module tb_axi_lite_cfg_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b1;
  logic [15:0] cmd_addr = '0, cmd_wdata = '0;
  logic        cmd_ready, rsp_valid, rsp_write, busy, timeout;
  logic [15:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  axi_lite_if #(.ADDR_W(16), .DATA_W(16)) axi();
  axi_lite_cfg_master #(.ADDR_W(16), .DATA_W(16), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
    .timeout(timeout), .axi(axi)
  );
  int n_cmp = 0, n_bad = 0, cyc = 0, bcount = 0;
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  bresp_k = 2'b00, rresp_k = 2'b00;
  logic [15:0] rdata_k = '0;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask
  // Slave: each ready/valid answers after the programmed number of waiting cycles
  initial begin
    int aw_n, w_n, b_n, ar_n, r_n;
    aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
    forever begin
      @(posedge clk); #1;
      axi.awready = axi.awvalid && aw_n >= aw_dly; aw_n = axi.awvalid ? aw_n + 1 : 0;
      axi.wready  = axi.wvalid && w_n >= w_dly;    w_n  = axi.wvalid ? w_n + 1 : 0;
      axi.arready = axi.arvalid && ar_n >= ar_dly; ar_n = axi.arvalid ? ar_n + 1 : 0;
      axi.bvalid  = axi.bready && b_n >= b_dly;    b_n  = axi.bready ? b_n + 1 : 0;
      axi.rvalid  = axi.rready && r_n >= r_dly;    r_n  = axi.rready ? r_n + 1 : 0;
      axi.bresp = bresp_k; axi.rdata = rdata_k; axi.rresp = rresp_k;
    end
  end
  // Transaction model: expected responses, outstanding/done status, stall-run timeout
  typedef struct {logic w; logic [15:0] d; logic [1:0] r;} rsp_t;
  rsp_t q[$];
  logic outst = 0, done = 0, exp_to = 0, r_prev = 1, started = 0;
  logic p_aw = 0, p_w = 0, p_ar = 0;
  logic [15:0] p_awaddr = 0, p_wdata = 0, p_araddr = 0, ea = 0, ed = 0;
  int run = 0;
  initial forever begin
    logic wait_ph, fin;
    @(posedge clk);
    cyc++;
    if (started && !r_prev) begin
      if (p_aw) begin chk("aw_hold", axi.awvalid, 1); chk("awaddr_stable", axi.awaddr, p_awaddr); end
      if (p_w)  begin chk("w_hold", axi.wvalid, 1); chk("wdata_stable", axi.wdata, p_wdata); end
      if (p_ar) begin chk("ar_hold", axi.arvalid, 1); chk("araddr_stable", axi.araddr, p_araddr); end
    end
    p_aw = axi.awvalid && !axi.awready; p_awaddr = axi.awaddr;
    p_w  = axi.wvalid && !axi.wready;   p_wdata  = axi.wdata;
    p_ar = axi.arvalid && !axi.arready; p_araddr = axi.araddr;
    if (rst) begin
      q.delete(); outst = 0; done = 0; exp_to = 0; run = 0; started = 1;
    end else if (started) begin
      if (axi.awvalid && axi.awready) chk("awaddr", axi.awaddr, ea);
      if (axi.wvalid && axi.wready) chk("wdata", axi.wdata, ed);
      if (axi.arvalid && axi.arready) chk("araddr", axi.araddr, ea);
      if (axi.bvalid && axi.bready) begin bcount++; done = 1; end
      if (axi.rvalid && axi.rready) done = 1;
      wait_ph = axi.awvalid || axi.wvalid || axi.arvalid || axi.bready || axi.rready;
      fin = ((axi.awvalid || axi.wvalid) && (!axi.awvalid || axi.awready) && (!axi.wvalid || axi.wready)) ||
            (axi.bready && axi.bvalid) || (axi.arvalid && axi.arready) || (axi.rready && axi.rvalid);
      if (wait_ph) begin
        if (fin) run = 0;
        else begin run++; if (run >= 8) exp_to = 1; end
      end
      if (cmd_valid && cmd_ready) begin
        q.push_back('{w: cmd_write, d: cmd_write ? 16'h0 : rdata_k, r: cmd_write ? bresp_k : rresp_k});
        outst = 1; exp_to = 0; run = 0; ea = cmd_addr; ed = cmd_wdata;
      end
      if (rsp_valid && rsp_ready) begin
        if (q.size() > 0) void'(q.pop_front());
        outst = 0; done = 0;
      end
    end
    r_prev = rst;
  end
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("busy", busy, outst);
      chk("cmd_ready", cmd_ready, !outst && !r_prev);
      chk("timeout", timeout, exp_to);
      chk("rsp_valid", rsp_valid, done);
      if (rsp_valid && q.size() > 0) begin
        chk("rsp_write", rsp_write, q[0].w);
        chk("rsp_rdata", rsp_rdata, q[0].d);
        chk("rsp_resp", rsp_resp, q[0].r);
      end
      if (r_prev) chk("bus_idle_after_rst", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 0);
    end
  end
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d, output int acc);
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1; acc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin acc = cyc; break; end
    end
    if (acc < 0) chk("accept_wait", cmd_ready, 1);
    step();
    cmd_valid = 0;
  endtask
  task automatic wait_rsp(output int t);
    t = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) begin t = cyc; break; end
    end
    if (t < 0) chk("rsp_wait", rsp_valid, 1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, rc, b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_awaddr", axi.awaddr, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    step();
    rst = 0;
    // 1: zero-wait write
    issue(1, 16'h0004, 16'h0080, n);
    @(negedge clk);
    chk("t1_aw_w_valid", {axi.awvalid, axi.wvalid}, 2'b11);
    wait_rsp(rc);
    chk("t1_latency", rc - n, 3);
    chk("t1_rsp_write", rsp_write, 1);
    chk("t1_rsp_rdata", rsp_rdata, 0);
    chk("t1_rsp_resp", rsp_resp, 0);
    step();
    // 2: W accepted at once, AW held until its fourth cycle
    aw_dly = 3; b0 = bcount;
    issue(1, 16'h0008, 16'h1234, n);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("t2_awvalid", axi.awvalid, k <= 4);
      chk("t2_wvalid", axi.wvalid, k == 1);
    end
    wait_rsp(rc);
    chk("t2_latency", rc - n, 6);
    chk("t2_b_count", bcount - b0, 1);
    aw_dly = 0;
    step();
    // 3: read with late RVALID
    r_dly = 2; rdata_k = 16'h00a5; rresp_k = 2'b00;
    issue(0, 16'h0100, 16'h0, n);
    wait_rsp(rc);
    chk("t3_latency", rc - n, 5);
    chk("t3_rsp_rdata", rsp_rdata, 16'h00a5);
    chk("t3_rsp_write", rsp_write, 0);
    r_dly = 0;
    step();
    // 4: SLVERR write, then a normal write
    bresp_k = 2'b10;
    issue(1, 16'h0020, 16'h0001, n);
    wait_rsp(rc);
    chk("t4_rsp_resp", rsp_resp, 2'b10);
    step();
    bresp_k = 2'b00;
    issue(1, 16'h0022, 16'h0002, n);
    wait_rsp(rc);
    chk("t4_next_latency", rc - n, 3);
    chk("t4_next_resp", rsp_resp, 2'b00);
    step();
    // 5: long AR stall trips the sticky timeout
    ar_dly = 20; rdata_k = 16'h005a;
    issue(0, 16'h0200, 16'h0, n);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("t5_timeout", timeout, k >= 9);
      chk("t5_arvalid", axi.arvalid, 1);
    end
    wait_rsp(rc);
    chk("t5_latency", rc - n, 23);
    chk("t5_rsp_rdata", rsp_rdata, 16'h005a);
    chk("t5_timeout_sticky", timeout, 1);
    step();
    ar_dly = 0;
    issue(1, 16'h0010, 16'h00ff, n);
    @(negedge clk);
    chk("t5_timeout_clear", timeout, 0);
    wait_rsp(rc);
    step();
    // 6: response backpressure, then reset during RD_R
    rsp_ready = 0; rdata_k = 16'h0077;
    issue(0, 16'h0300, 16'h0, n);
    wait_rsp(rc);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t6_hold_valid", rsp_valid, 1);
      chk("t6_hold_rdata", rsp_rdata, 16'h0077);
    end
    step();
    rsp_ready = 1;
    step();
    r_dly = 10;
    issue(0, 16'h0400, 16'h0, n);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (axi.rready) break;
    end
    chk("t6_in_rd_r", axi.rready, 1);
    step();
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_rsp_valid", rsp_valid, 0);
    step();
    rst = 0; r_dly = 0;
    issue(1, 16'h0004, 16'h0080, n);
    wait_rsp(rc);
    chk("t6_recover_latency", rc - n, 3);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
